// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 PRGA / decrypt stage.
package rc4_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned MSG_LEN_DEF = 32;
  localparam int unsigned K_W_DEF     = 5;
  localparam int unsigned ST_W        = 4;

  // Plaintext acceptance bounds: lowercase letters or space.
  localparam logic [BYTE_W-1:0] CHAR_LO = 8'h61;
  localparam logic [BYTE_W-1:0] CHAR_HI = 8'h7A;
  localparam logic [BYTE_W-1:0] CHAR_SP = 8'h20;

  // State encodings.
  localparam logic [ST_W-1:0] ST_IDLE   = 4'd0;
  localparam logic [ST_W-1:0] ST_RD_SI  = 4'd1;
  localparam logic [ST_W-1:0] ST_WT_SI  = 4'd2;
  localparam logic [ST_W-1:0] ST_CAP_SI = 4'd3;
  localparam logic [ST_W-1:0] ST_RD_SJ  = 4'd4;
  localparam logic [ST_W-1:0] ST_WT_SJ  = 4'd5;
  localparam logic [ST_W-1:0] ST_CAP_SJ = 4'd6;
  localparam logic [ST_W-1:0] ST_WR_SI  = 4'd7;
  localparam logic [ST_W-1:0] ST_WR_SJ  = 4'd8;
  localparam logic [ST_W-1:0] ST_RD_F   = 4'd9;
  localparam logic [ST_W-1:0] ST_WT_F   = 4'd10;
  localparam logic [ST_W-1:0] ST_CAP_F  = 4'd11;
  localparam logic [ST_W-1:0] ST_WR_DEC = 4'd12;
  localparam logic [ST_W-1:0] ST_DONE   = 4'd13;

  typedef enum logic [ST_W-1:0] {
    IDLE   = ST_IDLE,
    RD_SI  = ST_RD_SI,
    WT_SI  = ST_WT_SI,
    CAP_SI = ST_CAP_SI,
    RD_SJ  = ST_RD_SJ,
    WT_SJ  = ST_WT_SJ,
    CAP_SJ = ST_CAP_SJ,
    WR_SI  = ST_WR_SI,
    WR_SJ  = ST_WR_SJ,
    RD_F   = ST_RD_F,
    WT_F   = ST_WT_F,
    CAP_F  = ST_CAP_F,
    WR_DEC = ST_WR_DEC,
    DONE   = ST_DONE
  } state_e;

  // S memory request as presented on the S memory port.
  typedef struct packed {
    logic [BYTE_W-1:0] addr;
    logic [BYTE_W-1:0] data;
    logic              wen;
  } s_req_t;

endpackage

// File: rtl/rc4_char_checker.sv
// Flags a byte that is a lowercase ASCII letter or a space.
module rc4_char_checker
  import rc4_pkg::*;
(
  input  logic [BYTE_W-1:0] byte_i,
  output logic              is_text_o
);

  // Range compare against the package bounds plus the single space code.
  always_comb begin
    is_text_o = ((byte_i >= CHAR_LO) && (byte_i <= CHAR_HI)) || (byte_i == CHAR_SP);
  end

endmodule

// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generation over the KSA-prepared S memory, XOR with the
// encrypted ROM, plaintext written to the decrypted RAM, plus a whole-message
// "is text" verdict for the key-search controller.
module rc4_prga_decrypt
  import rc4_pkg::*;
#(
  parameter int unsigned MSG_LEN = MSG_LEN_DEF,
  parameter int unsigned K_W     = K_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              commenco,
  output logic              finito,
  output logic              msg_valid,
  output logic [BYTE_W-1:0] s_address,
  output logic [BYTE_W-1:0] s_data,
  output logic              s_wen,
  input  logic [BYTE_W-1:0] s_q,
  output logic [K_W-1:0]    rom_address,
  input  logic [BYTE_W-1:0] rom_q,
  output logic [K_W-1:0]    dec_address,
  output logic [BYTE_W-1:0] dec_data,
  output logic              dec_wen
);

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] i_q, i_d;
  logic [BYTE_W-1:0] j_q, j_d;
  logic [BYTE_W-1:0] si_q, si_d;
  logic [BYTE_W-1:0] sj_q, sj_d;
  logic [BYTE_W-1:0] f_q, f_d;
  logic [BYTE_W-1:0] enc_q, enc_d;
  logic [K_W-1:0]    k_q, k_d;
  logic              valid_acc_q, valid_acc_d;

  s_req_t            s_req_q, s_req_d;
  logic [K_W-1:0]    rom_addr_q, rom_addr_d;
  logic [K_W-1:0]    dec_addr_q, dec_addr_d;
  logic [BYTE_W-1:0] dec_data_q, dec_data_d;
  logic              dec_wen_q, dec_wen_d;
  logic              finito_q, finito_d;
  logic              msg_valid_q, msg_valid_d;

  logic [BYTE_W-1:0] plain_c;
  logic              plain_is_text_c;
  logic              last_byte_c;

  assign plain_c     = f_q ^ enc_q;
  assign last_byte_c = (k_q == K_W'(MSG_LEN - 1));

  rc4_char_checker u_char_checker (
    .byte_i    (plain_c),
    .is_text_o (plain_is_text_c)
  );

  // State, datapath and output registers; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      f_q         <= '0;
      enc_q       <= '0;
      k_q         <= '0;
      valid_acc_q <= 1'b0;
      s_req_q     <= '0;
      rom_addr_q  <= '0;
      dec_addr_q  <= '0;
      dec_data_q  <= '0;
      dec_wen_q   <= 1'b0;
      finito_q    <= 1'b0;
      msg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      f_q         <= f_d;
      enc_q       <= enc_d;
      k_q         <= k_d;
      valid_acc_q <= valid_acc_d;
      s_req_q     <= s_req_d;
      rom_addr_q  <= rom_addr_d;
      dec_addr_q  <= dec_addr_d;
      dec_data_q  <= dec_data_d;
      dec_wen_q   <= dec_wen_d;
      finito_q    <= finito_d;
      msg_valid_q <= msg_valid_d;
    end
  end

  // Next-state and next-output logic; write enables and finito default low.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    si_d        = si_q;
    sj_d        = sj_q;
    f_d         = f_q;
    enc_d       = enc_q;
    k_d         = k_q;
    valid_acc_d = valid_acc_q;
    s_req_d     = s_req_q;
    s_req_d.wen = 1'b0;
    rom_addr_d  = rom_addr_q;
    dec_addr_d  = dec_addr_q;
    dec_data_d  = dec_data_q;
    dec_wen_d   = 1'b0;
    finito_d    = 1'b0;
    msg_valid_d = msg_valid_q;

    case (state_q)
      IDLE: begin
        if (commenco) begin
          i_d         = 8'd1;
          j_d         = 8'd0;
          k_d         = '0;
          valid_acc_d = 1'b1;
          msg_valid_d = 1'b0;
          state_d     = RD_SI;
        end
      end
      RD_SI: begin
        s_req_d.addr = i_q;
        state_d      = WT_SI;
      end
      WT_SI: state_d = CAP_SI;
      CAP_SI: begin
        si_d    = s_q;
        j_d     = j_q + s_q;
        state_d = RD_SJ;
      end
      RD_SJ: begin
        s_req_d.addr = j_q;
        state_d      = WT_SJ;
      end
      WT_SJ: state_d = CAP_SJ;
      CAP_SJ: begin
        sj_d    = s_q;
        state_d = WR_SI;
      end
      // When i==j both writes hit one address; si==sj then, so order is harmless.
      WR_SI: begin
        s_req_d.addr = i_q;
        s_req_d.data = sj_q;
        s_req_d.wen  = 1'b1;
        state_d      = WR_SJ;
      end
      WR_SJ: begin
        s_req_d.addr = j_q;
        s_req_d.data = si_q;
        s_req_d.wen  = 1'b1;
        state_d      = RD_F;
      end
      RD_F: begin
        s_req_d.addr = si_q + sj_q;
        rom_addr_d   = k_q;
        state_d      = WT_F;
      end
      WT_F: state_d = CAP_F;
      CAP_F: begin
        f_d     = s_q;
        enc_d   = rom_q;
        state_d = WR_DEC;
      end
      WR_DEC: begin
        dec_addr_d  = k_q;
        dec_data_d  = plain_c;
        dec_wen_d   = 1'b1;
        valid_acc_d = valid_acc_q & plain_is_text_c;
        if (last_byte_c) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + K_W'(1);
          i_d     = i_q + 8'd1;
          state_d = RD_SI;
        end
      end
      DONE: begin
        finito_d    = 1'b1;
        msg_valid_d = valid_acc_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_address   = s_req_q.addr;
  assign s_data      = s_req_q.data;
  assign s_wen       = s_req_q.wen;
  assign rom_address = rom_addr_q;
  assign dec_address = dec_addr_q;
  assign dec_data    = dec_data_q;
  assign dec_wen     = dec_wen_q;
  assign finito      = finito_q;
  assign msg_valid   = msg_valid_q;

endmodule
